// File: rtl/spi_exe_pkg.sv
// Shared types and helpers for the SPI command/response slave.
package spi_exe_pkg;

  // Frame-level protocol states of the slave.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    CAPTURE = 2'd3
  } spi_state_t;

  // Bit positions of the execution-unit flags inside i_flags.
  localparam int FLAG_SF = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NF = 1;
  localparam int FLAG_BF = 0;

  // Command frame length: opcode followed by two operands.
  function automatic int frame_w(input int n, input int m);
    return n + 2 * m;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus one-cycle
// rise/fall pulses derived from the synchronised value.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values: shift the raw input through the synchroniser chain.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-history registers; reset to the line's idle level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = sync_q & ~prev_q;
  assign o_fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_exe_slave.sv
// SPI mode-0 slave: receives {oper, argA, argB}, hands the command to an
// execution unit, captures its result/flags and returns them on MISO in
// the following frame.
module spi_exe_slave
  import spi_exe_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 9
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_sclk,
  input  logic         i_cs_n,
  input  logic         i_mosi,
  output logic         o_miso,
  output logic [N-1:0] o_oper,
  output logic [M-1:0] o_argA,
  output logic [M-1:0] o_argB,
  output logic         o_valid,
  input  logic [M-1:0] i_result,
  input  logic [3:0]   i_flags,
  output logic         o_frame_err
);

  localparam int F   = frame_w(N, M);
  localparam int CW  = $clog2(F + 1);
  localparam int PAD = F - M - 4;
  localparam logic [CW-1:0] F_CNT = CW'(F);

  // Synchronised SPI pins
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic mosi_meta_q, mosi_meta_d;
  logic mosi_s_q, mosi_s_d;

  sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sclk),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_cs_n),
    .o_rise  (cs_rise),
    .o_fall  (cs_fall)
  );

  // MOSI goes through the same two-flop depth as SCLK, so the data bit seen
  // alongside a detected SCLK rise is the one the host presented at that edge.
  always_comb begin
    mosi_meta_d = i_mosi;
    mosi_s_d    = mosi_meta_q;
  end

  // MOSI synchroniser registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_meta_d;
      mosi_s_q    <= mosi_s_d;
    end
  end

  // Protocol state
  spi_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [F-1:0]   rx_q, rx_d;
  logic [F-1:0]   tx_q, tx_d;
  logic [F-1:0]   resp_q, resp_d;
  logic [N-1:0]   oper_q, oper_d;
  logic [M-1:0]   arga_q, arga_d;
  logic [M-1:0]   argb_q, argb_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;

  logic [F-1:0]   rx_shift;
  logic [CW-1:0]  cnt_inc;
  logic [F-1:0]   resp_word;

  assign rx_shift  = {rx_q[F-2:0], mosi_s_q};
  assign cnt_inc   = cnt_q + CW'(1);
  // Result and flags left-aligned, zero-filled to the frame length.
  assign resp_word = {i_result, i_flags[FLAG_SF], i_flags[FLAG_OF],
                      i_flags[FLAG_NF], i_flags[FLAG_BF], {PAD{1'b0}}};

  // Next-state, shift-register and output-latch logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    resp_d  = resp_q;
    oper_d  = oper_q;
    arga_d  = arga_q;
    argb_d  = argb_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // An SCLK edge arriving together with the CS fall is deliberately
        // not sampled: only the CS edge is acted on here.
        if (cs_fall) begin
          tx_d    = resp_q;
          rx_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          // Partial frame: drop the received bits, keep the last command.
          err_d   = (cnt_q != '0);
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_inc;
          if (cnt_inc == F_CNT) begin
            oper_d  = rx_shift[F-1 -: N];
            arga_d  = rx_shift[2*M-1 -: M];
            argb_d  = rx_shift[M-1:0];
            valid_d = 1'b1;
            state_d = DONE;
          end
        end else if (sclk_fall) begin
          tx_d = {tx_q[F-2:0], 1'b0};
        end
      end

      DONE: begin
        // valid_q marks the first DONE cycle; the capture follows it.
        // If CS already rose in that cycle, capture now so the result is
        // not lost, since the CS edge will not be seen again.
        if (valid_q) begin
          if (cs_rise) begin
            resp_d  = resp_word;
            state_d = IDLE;
          end else begin
            state_d = CAPTURE;
          end
        end else if (cs_rise) begin
          state_d = IDLE;
        end
      end

      CAPTURE: begin
        resp_d  = resp_word;
        state_d = cs_rise ? IDLE : DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Frame FSM registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      resp_q  <= '0;
      oper_q  <= '0;
      arga_q  <= '0;
      argb_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      resp_q  <= resp_d;
      oper_q  <= oper_d;
      arga_q  <= arga_d;
      argb_q  <= argb_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // MISO is only driven with data while a frame is being shifted.
  assign o_miso      = (state_q == SHIFT) ? tx_q[F-1] : 1'b0;
  assign o_oper      = oper_q;
  assign o_argA      = arga_q;
  assign o_argB      = argb_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_exe_slave.sv
// Directed bench for spi_exe_slave: drives SPI frames at 1/16 of the
// system clock and checks decode, response serialisation and error paths.
module tb_spi_exe_slave;

  localparam int F = 22;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [3:0] oper;
  logic [8:0] arga, argb;
  logic       valid, ferr;
  logic [8:0] result = 9'h0;
  logic [3:0] flags = 4'h0;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_exe_slave #(.N(4), .M(9)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sclk      (sclk),
    .i_cs_n      (cs_n),
    .i_mosi      (mosi),
    .o_miso      (miso),
    .o_oper      (oper),
    .o_argA      (arga),
    .o_argB      (argb),
    .o_valid     (valid),
    .i_result    (result),
    .i_flags     (flags),
    .o_frame_err (ferr)
  );

  // Count cycles in which each pulse output is high.
  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (ferr === 1'b1)  err_cnt   <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One SPI frame of nbits bits; MISO sampled at each SCLK rise, right-aligned.
  task automatic do_frame(input logic [F-1:0] mosi_w, input int nbits,
                          output logic [24:0] miso_w);
    miso_w = '0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < F) ? mosi_w[F-1-i] : 1'b0;
      #80;
      sclk = 1'b1;
      miso_w = {miso_w[23:0], miso};
      #80;
      sclk = 1'b0;
    end
    #80;
    cs_n = 1'b1;
    mosi = 1'b0;
    #640;
    $display("frame bits=%0d mosi=%06h miso=%07h oper=%h A=%h B=%h",
             nbits, mosi_w, miso_w, oper, arga, argb);
  endtask

  task automatic check_cmd(input string tag, input logic [3:0] eo,
                           input logic [8:0] ea, input logic [8:0] eb);
    check({tag, "_oper"}, {28'd0, oper}, {28'd0, eo});
    check({tag, "_argA"}, {23'd0, arga}, {23'd0, ea});
    check({tag, "_argB"}, {23'd0, argb}, {23'd0, eb});
  endtask

  initial begin
    logic [24:0] mw;
    int v0, e0;

    // Reset state
    #20;
    check("rst_oper",  {28'd0, oper}, 32'd0);
    check("rst_argA",  {23'd0, arga}, 32'd0);
    check("rst_argB",  {23'd0, argb}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr",  {31'd0, ferr}, 32'd0);
    check("rst_miso",  {31'd0, miso}, 32'd0);
    #80;
    rst_n = 1'b1;
    #100;

    // Frame 1: first after reset returns zeros
    result = 9'h002; flags = 4'b0001;
    v0 = valid_cnt; e0 = err_cnt;
    do_frame({4'h0, 9'h005, 9'h003}, F, mw);
    check("f1_miso", {10'd0, mw[21:0]}, 32'd0);
    check("f1_valid", valid_cnt - v0, 1);
    check("f1_ferr", err_cnt - e0, 0);
    check_cmd("f1", 4'h0, 9'h005, 9'h003);

    // Frame 2: returns frame 1's captured result
    result = 9'h1AB; flags = 4'b1010;
    v0 = valid_cnt;
    do_frame({4'h1, 9'h1FF, 9'h0F0}, F, mw);
    check("f2_miso", {10'd0, mw[21:0]}, {10'd0, 22'b000000010_0001_000000000});
    check("f2_valid", valid_cnt - v0, 1);
    check_cmd("f2", 4'h1, 9'h1FF, 9'h0F0);

    // Aborted frame after 10 bits
    v0 = valid_cnt; e0 = err_cnt;
    do_frame({4'hF, 9'h0AA, 9'h0AA}, 10, mw);
    check("ab_miso", {22'd0, mw[9:0]}, {22'd0, 10'b1101010111});
    check("ab_ferr", err_cnt - e0, 1);
    check("ab_valid", valid_cnt - v0, 0);
    check_cmd("ab", 4'h1, 9'h1FF, 9'h0F0);

    // Frame 3: response untouched by the abort
    result = 9'h0FF; flags = 4'b0110;
    v0 = valid_cnt;
    do_frame({4'h3, 9'h0AA, 9'h155}, F, mw);
    check("f3_miso", {10'd0, mw[21:0]}, {10'd0, 9'h1AB, 4'b1010, 9'h000});
    check("f3_valid", valid_cnt - v0, 1);
    check_cmd("f3", 4'h3, 9'h0AA, 9'h155);

    // Frame 4 back-to-back: returns frame 3's captured result
    result = 9'h055; flags = 4'b1100;
    do_frame({4'h1, 9'h1FF, 9'h0F0}, F, mw);
    check("f4_miso", {10'd0, mw[21:0]}, {10'd0, 9'h0FF, 4'b0110, 9'h000});
    check_cmd("f4", 4'h1, 9'h1FF, 9'h0F0);

    // Frame 5: 25 SCLK cycles, extra bits ignored
    v0 = valid_cnt; e0 = err_cnt;
    do_frame({4'h2, 9'h100, 9'h001}, 25, mw);
    check("f5_miso", {10'd0, mw[24:3]}, {10'd0, 9'h055, 4'b1100, 9'h000});
    check("f5_miso_tail", {29'd0, mw[2:0]}, 32'd0);
    check("f5_valid", valid_cnt - v0, 1);
    check("f5_ferr", err_cnt - e0, 0);
    check_cmd("f5", 4'h2, 9'h100, 9'h001);

    // Reset asserted at bit 12 of a frame
    result = 9'h1C3; flags = 4'b1111;
    cs_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mosi = i[0];
      #80;
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mr_oper",  {28'd0, oper}, 32'd0);
    check("mr_argA",  {23'd0, arga}, 32'd0);
    check("mr_argB",  {23'd0, argb}, 32'd0);
    check("mr_valid", {31'd0, valid}, 32'd0);
    check("mr_miso",  {31'd0, miso}, 32'd0);
    $display("reset asserted mid-frame at bit 12");
    #9;
    cs_n = 1'b1;
    mosi = 1'b0;
    #100;
    rst_n = 1'b1;
    #200;

    // Frame 6: response register was cleared by reset
    v0 = valid_cnt;
    do_frame({4'h5, 9'h011, 9'h022}, F, mw);
    check("f6_miso", {10'd0, mw[21:0]}, 32'd0);
    check("f6_valid", valid_cnt - v0, 1);
    check_cmd("f6", 4'h5, 9'h011, 9'h022);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
